// File: rtl/obc_pkg.sv
// Shared types and constants for the OBC distributed-arithmetic DFT datapath.
// A Q10.21 ROM word is aligned to the accumulator format by sign extension plus GUARD extra fraction bits.
package obc_pkg;

    localparam int ROM_W    = 32;
    localparam int ROM_FRAC = 21;
    localparam int GUARD    = 8;
    localparam int SUM_W    = ROM_W + 3;
    localparam int ACC_W    = SUM_W + GUARD;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // The ACC_W - SUM_W difference is exactly GUARD, so alignment is a pure left shift.
    function automatic logic signed [ACC_W-1:0] align_q(input logic signed [SUM_W-1:0] w);
        return $signed({w, {GUARD{1'b0}}});
    endfunction

endpackage

// File: rtl/obc_shift_accumulate_if.sv
// Slice/result bus between the OBC ROM bank and one shift-accumulator instance.
interface obc_shift_accumulate_if #(
    parameter int ROM_W = obc_pkg::ROM_W,
    parameter int ACC_W = obc_pkg::ACC_W
);
    logic                    start;
    logic signed [ROM_W-1:0] offset;
    logic                    in_valid;
    logic signed [ROM_W-1:0] rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7;
    logic                    busy;
    logic                    out_valid;
    logic signed [ACC_W-1:0] y;

    modport master (
        output start, offset, in_valid,
        output rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7,
        input  busy, out_valid, y
    );

    modport slave (
        input  start, offset, in_valid,
        input  rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7,
        output busy, out_valid, y
    );
endinterface

// File: rtl/obc_sum8.sv
// Combinational signed adder tree over the eight ROM outputs of one bit-slice.
// Each tree level grows by one bit, so no intermediate sum can wrap.
module obc_sum8
    import obc_pkg::*;
(
    input  logic signed [ROM_W-1:0] rom [8],
    output logic signed [SUM_W-1:0] sum
);
    logic signed [ROM_W:0]   lvl1 [4];
    logic signed [ROM_W+1:0] lvl2 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = (ROM_W+1)'(rom[2*i]) + (ROM_W+1)'(rom[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            lvl2[i] = (ROM_W+2)'(lvl1[2*i]) + (ROM_W+2)'(lvl1[2*i+1]);
        end
        sum = SUM_W'(lvl2[0]) + SUM_W'(lvl2[1]);
    end
endmodule

// File: rtl/obc_shift_accumulate.sv
// DA shift-accumulator: folds DATA_W slice sums LSB first, subtracts the MSB (sign) slice,
// then adds the per-bin OBC offset to form one DFT output component.
module obc_shift_accumulate
    import obc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    obc_shift_accumulate_if.slave bus
);
    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    // Dropping the LSB (floor) is the only rounding in the datapath.
    function automatic logic signed [ACC_W-1:0] trunc_half(input logic signed [ACC_W-1:0] x);
        return x >>> 1;
    endfunction

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] y_r;
    logic signed [ROM_W-1:0] off_r;
    logic                    busy_r;
    logic                    out_valid_r;

    logic signed [ROM_W-1:0] rom [8];
    logic signed [SUM_W-1:0] slice_sum;
    logic signed [ACC_W-1:0] s_al;
    logic signed [ACC_W-1:0] off_al;

    assign rom[0] = bus.rom0;
    assign rom[1] = bus.rom1;
    assign rom[2] = bus.rom2;
    assign rom[3] = bus.rom3;
    assign rom[4] = bus.rom4;
    assign rom[5] = bus.rom5;
    assign rom[6] = bus.rom6;
    assign rom[7] = bus.rom7;

    obc_sum8 u_sum8 (
        .rom (rom),
        .sum (slice_sum)
    );

    assign s_al   = align_q(slice_sum);
    assign off_al = align_q(SUM_W'(off_r));

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            off_r       <= '0;
            y_r         <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        off_r  <= bus.offset;
                        busy_r <= 1'b1;
                        state  <= ACCUM;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (cnt == LAST) begin
                            // MSB slice carries negative weight in two's complement.
                            y_r         <= acc - s_al + off_al;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state       <= DONE;
                        end else begin
                            acc <= trunc_half(acc + s_al);
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_obc_shift_accumulate.sv
// Bench for obc_shift_accumulate: directed vector table, multi-cycle corner sequences,
// and randomized results checked against a closed-form arithmetic model.
module tb_obc_shift_accumulate;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obc_shift_accumulate_if #(.ROM_W(32), .ACC_W(43)) bus ();

    obc_shift_accumulate #(.DATA_W(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [31:0] sl [N][8];
    int                 gap [N];
    logic signed [31:0] off_v;
    logic               hold_start = 1'b0;

    typedef struct {
        int                 mode;   // 0: all eight roms on every slice, 1: rom0 on one slice only
        int                 slice;
        logic signed [31:0] romv;
        logic signed [31:0] off;
        longint             exp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Closed form: successive floor-halvings equal one floor of the weighted total.
    function automatic longint model_y();
        longint s [N];
        longint t = 0;
        for (int b = 0; b < N; b++) begin
            s[b] = 0;
            for (int r = 0; r < 8; r++) s[b] += longint'(sl[b][r]);
            s[b] = s[b] * 256;
        end
        for (int b = 0; b < N - 1; b++) t += s[b] * (longint'(1) << b);
        return (t >>> (N - 1)) - s[N-1] + longint'(off_v) * 256;
    endfunction

    task automatic drive_slice(input int k);
        bus.rom0 = sl[k][0]; bus.rom1 = sl[k][1]; bus.rom2 = sl[k][2]; bus.rom3 = sl[k][3];
        bus.rom4 = sl[k][4]; bus.rom5 = sl[k][5]; bus.rom6 = sl[k][6]; bus.rom7 = sl[k][7];
    endtask

    task automatic drive_garbage();
        bus.rom0 = $urandom; bus.rom1 = $urandom; bus.rom2 = $urandom; bus.rom3 = $urandom;
        bus.rom4 = $urandom; bus.rom5 = $urandom; bus.rom6 = $urandom; bus.rom7 = $urandom;
    endtask

    task automatic clear_slices();
        for (int b = 0; b < N; b++) begin
            gap[b] = 0;
            for (int r = 0; r < 8; r++) sl[b][r] = '0;
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that should raise out_valid.
    task automatic run_result(input string tag, input longint exp, input bit tail);
        bus.start    = 1'b1;
        bus.offset   = off_v;
        bus.in_valid = 1'b1;
        drive_garbage();
        @(posedge clk); #1;
        bus.start = hold_start;
        chk({tag, "_busy"}, longint'(bus.busy), 1);
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                bus.in_valid = 1'b0;
                drive_garbage();
                @(posedge clk); #1;
            end
            if (k == N - 1) chk({tag, "_early_vld"}, longint'(bus.out_valid), 0);
            drive_slice(k);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk({tag, "_vld"}, longint'(bus.out_valid), 1);
        chk({tag, "_y"}, longint'(bus.y), exp);
        if (tail) begin
            @(posedge clk); #1;
            chk({tag, "_vld_drop"}, longint'(bus.out_valid), 0);
            chk({tag, "_y_hold"}, longint'(bus.y), exp);
            chk({tag, "_idle"}, longint'(bus.busy), 0);
        end
    endtask

    task automatic load_vec(input vec_t v);
        clear_slices();
        off_v = v.off;
        if (v.mode == 0) begin
            for (int b = 0; b < N; b++)
                for (int r = 0; r < 8; r++) sl[b][r] = v.romv;
        end else begin
            sl[v.slice][0] = v.romv;
        end
    endtask

    initial begin
        vecs[0] = '{mode: 0, slice: 0,  romv: 32'h0020_0000, off: 32'h0000_0000, exp: -64'sd131072};
        vecs[1] = '{mode: 1, slice: 15, romv: 32'h0020_0000, off: 32'h0010_0000, exp: -64'sd268435456};
        vecs[2] = '{mode: 1, slice: 0,  romv: 32'h0020_0000, off: 32'h0000_0000, exp: 64'sd16384};
        vecs[3] = '{mode: 0, slice: 0,  romv: 32'h0020_0000, off: 32'hFFE0_0000, exp: -64'sd537001984};

        bus.start = 1'b0; bus.offset = '0; bus.in_valid = 1'b0;
        clear_slices();
        drive_slice(0);
        off_v = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_vld", longint'(bus.out_valid), 0);
        chk("rst_y", longint'(bus.y), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load_vec(vecs[i]);
            run_result($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
        end

        // Slices outside ACCUM must be ignored.
        bus.in_valid = 1'b1;
        repeat (3) begin
            drive_garbage();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("idle_vld", longint'(bus.out_valid), 0);
        chk("idle_busy", longint'(bus.busy), 0);
        chk("idle_y", longint'(bus.y), vecs[3].exp);

        // Stalls: three random gaps delay out_valid without changing y.
        load_vec(vecs[0]);
        for (int i = 0; i < 3; i++) gap[$urandom_range(0, N - 1)] += 1;
        run_result("stall", vecs[0].exp, 1'b1);

        // Reset mid-accumulation.
        load_vec(vecs[0]);
        bus.start = 1'b1; bus.offset = off_v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_slice(k); bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_vld", longint'(bus.out_valid), 0);
        chk("midrst_y", longint'(bus.y), 0);
        run_result("after_rst", vecs[0].exp, 1'b1);

        // start held high throughout ACCUM is ignored.
        load_vec(vecs[2]);
        hold_start = 1'b1;
        run_result("hold_start", vecs[2].exp, 1'b1);
        hold_start = 1'b0;

        // Back-to-back: second start issued in the DONE cycle.
        load_vec(vecs[0]);
        run_result("b2b_a", vecs[0].exp, 1'b0);
        load_vec(vecs[1]);
        run_result("b2b_b", vecs[1].exp, 1'b1);

        // Randomized results against the model.
        for (int it = 0; it < 8; it++) begin
            clear_slices();
            for (int b = 0; b < N; b++) begin
                gap[b] = ($urandom_range(0, 7) == 0) ? 1 : 0;
                for (int r = 0; r < 8; r++)
                    sl[b][r] = $signed($urandom_range(0, 32'h0FFF_FFFF)) - 32'sh0800_0000;
            end
            off_v = $signed($urandom_range(0, 32'h0FFF_FFFF)) - 32'sh0800_0000;
            run_result($sformatf("rand%0d", it), model_y(), (it % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/obc_shift_accumulate.md
# obc_shift_accumulate

Distributed-arithmetic shift-accumulator directly downstream of the OBC partial-sum ROM bank in the 16-point DFT datapath. Each cycle it sums the eight 32-bit ROM outputs for one input bit-slice and folds them into a right-shifting accumulator, LSB slice first. On the MSB slice it subtracts instead of adds, then adds the per-bin OBC offset constant. One instance produces one DFT output component (real or imaginary) per DATA_W slices.

## Interface

- DATA_W, 16: input sample width (number of bit-slices per result), ≥2
- ROM_W, 32: ROM word width, signed Q10.21
- GUARD, 8: extra fractional guard bits below the ROM LSB
- ACC_W, ROM_W+3+GUARD (43): accumulator/result width, signed, FRAC = 21+GUARD
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  begin a new result; latches offset
- offset  in  ROM_W  OBC offset constant (Q10.21), sampled on accepted start
- in_valid  in  1  slice presented this cycle
- rom0..rom7  in  ROM_W each  ROM outputs for the current slice
- busy  out  1  high in ACCUM
- out_valid  out  1  one-cycle result strobe
- y  out  ACC_W  result, held until the next accepted start

## Operation

- States: IDLE, ACCUM, DONE. Reset gives IDLE with acc=0, cnt=0, busy=0, out_valid=0, y=0.
- start is accepted in IDLE or DONE. On acceptance: acc←0, cnt←0, off_r←offset, next state ACCUM. start in ACCUM is ignored.
- Slice sum: S = sign-extended sum of rom0..rom7 to ROM_W+3 bits, left-shifted by GUARD to ACC_W.
- In ACCUM with in_valid=1:
  - cnt < DATA_W-1: acc ← (acc + S) >>> 1 (arithmetic; LSB dropped); cnt++.
  - cnt = DATA_W-1 (MSB slice): y ← acc − S + (sext(off_r) << GUARD); next state DONE.
- in_valid=0 in ACCUM stalls the block. acc and cnt are held, and there is no timeout.
- in_valid in IDLE or DONE is ignored.
- DONE lasts exactly one cycle with out_valid=1, then goes to IDLE unless start is accepted in that cycle.
- Result: y = −S_{DATA_W−1} + Σ_{b<DATA_W−1} S_b·2^{−(DATA_W−1−b)} + offset. The only error is truncation from the right shifts.
- Overflow: none is possible for ROM magnitudes < 2^10/8. No saturation logic.
- rst in any state, including mid-ACCUM or DONE, overrides everything and returns to the reset values within one cycle.

## Timing

- Slice k is consumed on the edge where in_valid=1 in ACCUM.
- With no stalls: start at cycle 0, slices at cycles 1..DATA_W, out_valid at cycle DATA_W+1.
- The first slice may accompany the cycle immediately after start; a slice coincident with start is not consumed.
- out_valid and y are registered. y is updated on the same edge that raises out_valid.
- Back-to-back operation: start asserted in the DONE cycle gives one result every DATA_W+1 cycles.
- All inputs are sampled on the rising clk edge. There are no combinational input→output paths.

## Structure

- Package obc_pkg holds:
  - ROM_W=32, ROM_FRAC=21
  - the state enum {IDLE, ACCUM, DONE}
  - a function aligning a Q10.21 word to accumulator format (sign-extend, shift by GUARD)
- Sub-module obc_sum8: combinational 8-input signed adder tree, ROM_W in, ROM_W+3 out. It is reused by the DFT bin-parallel top level.
- Top contains the FSM, cnt (clog2(DATA_W) bits), acc, off_r and y registers.

## Test plan

- All rom=32'h0020_0000 (1.0), offset=0, 16 unstalled slices → S=8.0; y=−2^−12 (ACC_W integer −131072); out_valid at cycle 17 for one cycle.
- Only rom0=1.0 on the MSB slice, all else 0, offset=32'h0010_0000 (0.5) → y=−0.5 (integer −2^28).
- Only rom0=1.0 on slice 0 (LSB), offset=0 → y=2^−15 (integer 2^14).
- Repeat case 1 with in_valid low for 3 random gaps → identical y, with out_valid delayed by exactly the stall count.
- rst pulsed after 5 slices → next cycle busy=0, out_valid=0, y=0; a fresh start plus 16 slices reproduces case 1 exactly.
- start held during ACCUM is ignored (y unchanged). start in the DONE cycle begins the next result, with the second out_valid exactly 17 cycles after the first.
